// File: rtl/div_iter.sv
// div_iter: radix-2 restoring iterative divider with annul, divide-by-zero flag and busy.
// Define DIV_EARLY_TERM_EN to skip the dividend's leading zeros and finish early.
module div_iter #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               signed_div_i,
    input  logic [WIDTH-1:0]   opdata1_i,
    input  logic [WIDTH-1:0]   opdata2_i,
    input  logic               start_i,
    input  logic               annul_i,
    output logic [2*WIDTH-1:0] result_o,
    output logic               ready_o,
    output logic               busy_o,
    output logic               div_zero_o
);
    localparam int CW = $clog2(WIDTH + 1);
    typedef enum logic [1:0] {IDLE, BY_ZERO, ON, END} state_t;
    state_t state;
    logic [WIDTH-1:0] dvd, dsr, rem, abs_a, abs_b, rem_n, quo_n, diff, start_dvd;
    logic [WIDTH:0] r_sh;
    logic [1:0] borrow;
    logic [CW-1:0] cnt, steps;
    logic neg_a, neg_b, q_neg, r_neg, ge;
    always_comb begin
        neg_a = signed_div_i & opdata1_i[WIDTH-1];
        neg_b = signed_div_i & opdata2_i[WIDTH-1];
        abs_a = neg_a ? -opdata1_i : opdata1_i;
        abs_b = neg_b ? -opdata2_i : opdata2_i;
        r_sh = {rem, dvd[WIDTH-1]};
        {borrow, diff} = {1'b0, r_sh} - {2'b00, dsr};
        ge = ~|borrow;
        rem_n = ge ? diff : r_sh[WIDTH-1:0];
        quo_n = {dvd[WIDTH-2:0], ge};
    end
    // dvd doubles as the quotient: dividend bits leave at the top, quotient bits enter at the bottom
`ifdef DIV_EARLY_TERM_EN
    logic [CW-1:0] clz;
    always_comb begin
        clz = CW'(WIDTH);
        for (int i = 0; i < WIDTH; i++) if (abs_a[i]) clz = CW'(WIDTH - 1 - i);
    end
    assign steps = (clz == CW'(WIDTH)) ? CW'(1) : CW'(WIDTH) - clz;
    assign start_dvd = abs_a << clz;
`else
    assign steps = CW'(WIDTH);
    assign start_dvd = abs_a;
`endif
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            result_o <= '0;
            ready_o <= 1'b0;
            busy_o <= 1'b0;
            div_zero_o <= 1'b0;
            cnt <= '0;
            dvd <= '0;
            dsr <= '0;
            rem <= '0;
            q_neg <= 1'b0;
            r_neg <= 1'b0;
        end else begin
            case (state)
                IDLE: if (start_i && !annul_i) begin
                    busy_o <= 1'b1;
                    if (opdata2_i == '0) state <= BY_ZERO;
                    else begin
                        state <= ON;
                        dvd <= start_dvd;
                        dsr <= abs_b;
                        rem <= '0;
                        cnt <= steps;
                        q_neg <= neg_a ^ neg_b;
                        r_neg <= neg_a;
                    end
                end
                BY_ZERO: begin
                    busy_o <= 1'b0;
                    state <= annul_i ? IDLE : END;
                    if (!annul_i) begin
                        result_o <= '0;
                        div_zero_o <= 1'b1;
                        ready_o <= 1'b1;
                    end
                end
                ON: if (annul_i) begin
                    state <= IDLE;
                    busy_o <= 1'b0;
                end else if (cnt == CW'(1)) begin
                    state <= END;
                    busy_o <= 1'b0;
                    ready_o <= 1'b1;
                    result_o <= {r_neg ? -rem_n : rem_n, q_neg ? -quo_n : quo_n};
                end else begin
                    rem <= rem_n;
                    dvd <= quo_n;
                    cnt <= cnt - CW'(1);
                end
                END: if (!start_i || annul_i) begin
                    state <= IDLE;
                    ready_o <= 1'b0;
                    div_zero_o <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_div_iter.sv
// tb_div_iter: directed self-checking bench for div_iter at WIDTH=32 with an arithmetic reference model.
module tb_div_iter;
    logic clk = 0, rst = 1, signed_div_i = 0, start_i = 0, annul_i = 0;
    logic [31:0] opdata1_i = 0, opdata2_i = 0;
    logic [63:0] result_o;
    logic ready_o, busy_o, div_zero_o;
    int total = 0, bad = 0, cyc = 0, t0 = 0, td = 0, ta = 0, n_exp = 1;
    logic [63:0] exp_res = 0, got;
    logic exp_dz = 0;
    int rc;
`ifdef DIV_EARLY_TERM_EN
    localparam int LAT100 = 8, LAT0 = 2;
`else
    localparam int LAT100 = 33, LAT0 = 33;
`endif

    div_iter #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst), .signed_div_i(signed_div_i), .opdata1_i(opdata1_i),
        .opdata2_i(opdata2_i), .start_i(start_i), .annul_i(annul_i), .result_o(result_o),
        .ready_o(ready_o), .busy_o(busy_o), .div_zero_o(div_zero_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b, input logic s);
        longint sa, sb, q, r;
        if (b == 0) return '0;
        sa = s ? longint'($signed(a)) : longint'(a);
        sb = s ? longint'($signed(b)) : longint'(b);
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
    endfunction

    function automatic int steps_of(input logic [31:0] a, input logic s);
`ifdef DIV_EARLY_TERM_EN
        longint m;
        int n;
        m = s ? longint'($signed(a)) : longint'(a);
        if (m < 0) m = -m;
        n = 1;
        for (int i = 0; i < 40; i++) if (m >= (longint'(1) << i)) n = i + 1;
        return n;
`else
        return (a == 0 && s == 0) ? 32 : 32;
`endif
    endfunction

    // Per-cycle timing model: busy during the N steps, ready from N+1 until start drops or annul
    always @(negedge clk) if (!rst) begin
        int k;
        logic eb, er;
        k = cyc - t0;
        eb = k >= 1 && k <= n_exp && cyc <= ta;
        er = k >= n_exp + 1 && cyc <= td && cyc <= ta;
        chk("busy", {63'b0, busy_o}, {63'b0, eb});
        chk("ready", {63'b0, ready_o}, {63'b0, er});
        if (er) begin
            chk("result", result_o, exp_res);
            chk("div_zero", {63'b0, div_zero_o}, {63'b0, exp_dz});
        end
    end

    task automatic arm(input logic [31:0] a, input logic [31:0] b, input logic s);
        @(posedge clk); #2;
        opdata1_i = a; opdata2_i = b; signed_div_i = s; start_i = 1; annul_i = 0;
        t0 = cyc; td = 1 << 30; ta = 1 << 30;
        exp_res = model(a, b, s);
        exp_dz = (b == 0);
        n_exp = (b == 0) ? 1 : steps_of(a, s);
    endtask

    task automatic run(input logic [31:0] a, input logic [31:0] b, input logic s, input int hold,
                       output logic [63:0] res, output int lat);
        arm(a, b, s);
        res = '0;
        lat = -1;
        for (int i = 0; i < 200 && lat < 0; i++) begin
            @(posedge clk); #2;
            if (i == 0) begin opdata1_i = ~a; opdata2_i = b + 32'd3; signed_div_i = ~s; end
            if (ready_o) begin res = result_o; lat = cyc - t0; end
        end
        if (lat < 0) begin
            total++; bad++;
            $display("FAIL timeout: ready never rose for %h / %h", a, b);
        end
        repeat (hold) begin @(posedge clk); #2; end
        start_i = 0;
        td = cyc;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #2;
        chk("rst_result", result_o, 64'h0);
        chk("rst_ready", {63'b0, ready_o}, 64'h0);
        chk("rst_busy", {63'b0, busy_o}, 64'h0);
        chk("rst_div_zero", {63'b0, div_zero_o}, 64'h0);
        rst = 0;

        run(32'd100, 32'd7, 0, 0, got, rc);
        chk("u100_7", got, 64'h00000002_0000000E);
        chk("u100_7_lat", 64'(rc), 64'(LAT100));
        run(32'hFFFFFFF9, 32'd2, 1, 0, got, rc);
        chk("s_m7_2", got, 64'hFFFFFFFF_FFFFFFFD);
        run(32'd7, 32'hFFFFFFFE, 1, 0, got, rc);
        chk("s_7_m2", got, 64'h00000001_FFFFFFFD);
        run(32'd5, 32'd0, 0, 0, got, rc);
        chk("u5_0", got, 64'h0);
        chk("u5_0_lat", 64'(rc), 64'd2);
        run(32'd5, 32'd0, 1, 2, got, rc);
        chk("s5_0_lat", 64'(rc), 64'd2);
        run(32'h80000000, 32'hFFFFFFFF, 1, 0, got, rc);
        chk("s_min_m1", got, 64'h00000000_80000000);

        @(posedge clk); #2;
        start_i = 1; annul_i = 1; opdata1_i = 32'd50; opdata2_i = 32'd5;
        repeat (3) begin @(posedge clk); #2; end
        start_i = 0; annul_i = 0;

        arm(32'd100, 32'd7, 0);
        repeat (10) begin @(posedge clk); #2; end
        annul_i = 1; start_i = 0; ta = cyc; td = cyc;
        @(posedge clk); #2;
        annul_i = 0;
        chk("annul_idle_busy", {63'b0, busy_o}, 64'h0);
        repeat (40) begin @(posedge clk); #2; end

        run(32'd9, 32'd3, 0, 5, got, rc);
        chk("u9_3", got, 64'h00000000_00000003);
        run(32'd0, 32'd7, 0, 5, got, rc);
        chk("u0_7", got, 64'h0);
        chk("u0_7_lat", 64'(rc), 64'(LAT0));
        run(32'hFFFFFF9C, 32'd7, 1, 0, got, rc);
        chk("s_m100_7", got, 64'hFFFFFFFE_FFFFFFF2);
        run(32'hFFFFFFFF, 32'd1, 0, 0, got, rc);
        run(32'hFFFFFFFF, 32'hFFFFFFFF, 0, 1, got, rc);
        run(32'd123456789, 32'h10000, 0, 0, got, rc);
        run(32'h80000000, 32'd3, 1, 0, got, rc);

        arm(32'd100, 32'd7, 0);
        repeat (5) begin @(posedge clk); #2; end
        chk("busy_before_rst", {63'b0, busy_o}, 64'h1);
        rst = 1;
        #1;
        chk("arst_result", result_o, 64'h0);
        chk("arst_ready", {63'b0, ready_o}, 64'h0);
        chk("arst_busy", {63'b0, busy_o}, 64'h0);
        chk("arst_div_zero", {63'b0, div_zero_o}, 64'h0);
        ta = 0; td = 0; start_i = 0;
        @(posedge clk); #2;
        rst = 0;

        run(32'd100, 32'd7, 0, 0, got, rc);
        chk("u100_7_after_rst", got, 64'h00000002_0000000E);
        repeat (3) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/div_iter.md
# div_iter

Parametrised iterative integer divider for the execute stage of the five-stage MIPS core. It takes over from the fixed 32-bit divider and adds a configurable operand width, a functional annul input, a divide-by-zero flag and a busy indication. Operation is radix-2 restoring shift-subtract. The EX stage requests the divide and stalls the pipeline until `ready_o`; results are then written to HI/LO.

## Interface

Parameters:
- `WIDTH`, default 32: operand width in bits; legal range 8 to 64.

Ports:
- `clk` input 1: single clock, rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `signed_div_i` input 1: 1 selects two's-complement divide, 0 selects unsigned divide.
- `opdata1_i` input WIDTH: dividend.
- `opdata2_i` input WIDTH: divisor.
- `start_i` input 1: request; held high by the requester until `ready_o` is seen.
- `annul_i` input 1: abort the current operation.
- `result_o` output 2*WIDTH: `{remainder, quotient}`; registered.
- `ready_o` output 1: result valid; registered.
- `busy_o` output 1: high while a divide is in progress.
- `div_zero_o` output 1: the result belongs to a divide by zero; registered.

## Operation

- Four states: IDLE, BY_ZERO, ON, END.
- Reset values:
  - state = IDLE.
  - `result_o` = 0, `ready_o` = 0, `busy_o` = 0, `div_zero_o` = 0.
  - Iteration counter = 0.
- IDLE:
  - Accept when `start_i`=1 and `annul_i`=0.
  - If `opdata2_i`=0, go to BY_ZERO.
  - Otherwise latch |dividend| and |divisor| and go to ON. Absolute values are taken only when `signed_div_i`=1 and the operand MSB is 1.
  - Also latch the quotient sign (MSB XOR, signed mode only) and the remainder sign (dividend MSB, signed mode only).
- BY_ZERO: one cycle, then END with `result_o`=0 and `div_zero_o`=1.
- ON, one step per cycle:
  - Shift the partial remainder left, bringing in the next dividend bit.
  - Trial-subtract the divisor, which needs a (WIDTH+1)-bit difference.
  - If the difference is non-negative, keep it and shift in quotient bit 1; otherwise shift in 0.
- Leaving ON:
  - After the final step, the sign fixup is applied as the value is registered into `result_o`.
  - The quotient is negated if the quotient sign is set; the remainder is negated if the remainder sign is set.
  - Next state is END.
- Signed overflow: minimum-negative / -1 gives quotient = minimum-negative (wraps) and remainder = 0. No flag is raised.
- END:
  - `ready_o`=1; `result_o` and `div_zero_o` are stable.
  - Stay in END while `start_i`=1; no restart occurs.
  - Go to IDLE when `start_i`=0 or `annul_i`=1.
- Leaving END for IDLE clears `ready_o` and `div_zero_o`. `result_o` holds its value until the next accepted start.
- Annul: `annul_i`=1 in BY_ZERO or ON returns to IDLE on the next edge; `ready_o` is never raised for that request. Annul has priority over completion in the same cycle.
- Start with `annul_i`=1 in IDLE is ignored.
- `busy_o`=1 exactly in BY_ZERO and ON.
- Operand inputs are sampled only at acceptance; later changes have no effect.

## Timing

- Cycle 0: the edge at the end of this cycle accepts the start.
- Non-zero divisor:
  - ON occupies cycles 1..N, where N = WIDTH by default (see Configuration).
  - `ready_o` rises in cycle N+1, so latency is WIDTH+1 cycles.
- Zero divisor: BY_ZERO in cycle 1, `ready_o` in cycle 2.
- `ready_o` falls one cycle after `start_i` drops. The earliest new acceptance is the cycle after returning to IDLE.
- `rst` asserted mid-operation forces all outputs to their reset values immediately, without waiting for a clock edge.
- Back-to-back throughput: one divide every N+3 cycles (accept, N steps, END, IDLE).

## Configuration

- `DIV_EARLY_TERM_EN`, when defined:
  - At acceptance, compute clz(|dividend|) and pre-shift the dividend by that amount.
  - N = max(1, WIDTH − clz). A zero dividend takes 1 step.
  - The result is bit-identical to the default build.
- Not defined: N = WIDTH always, and the leading-zero logic is absent.

## Test plan

- WIDTH=32, unsigned 100/7 → `result_o` = {0x00000002, 0x0000000E}; `ready_o` high in cycle 33; `div_zero_o`=0.
- Signed −7/2 (0xFFFFFFF9 / 0x00000002) → quotient 0xFFFFFFFD, remainder 0xFFFFFFFF. Signed 7/−2 → quotient 0xFFFFFFFD, remainder 0x00000001.
- 5/0, either mode → `busy_o` high in cycle 1 only; `ready_o` and `div_zero_o` high in cycle 2; `result_o`=0.
- Signed 0x80000000 / 0xFFFFFFFF → quotient 0x80000000, remainder 0.
- Annul and abort behaviour:
  - `annul_i` pulsed in cycle 10 of 100/7 → IDLE in cycle 11; `ready_o` never rises.
  - A new start of 9/3 then completes normally with quotient 3, remainder 0.
  - `rst` pulsed mid-ON → all outputs 0 with no clock edge.
- `DIV_EARLY_TERM_EN` defined:
  - Unsigned 100/7 → same result; `ready_o` in cycle 8 (clz=25, N=7).
  - 0/7 → result 0; `ready_o` in cycle 2.
  - Holding `start_i` high 5 cycles past ready → no restart.
